mix_sar_ctrl: RTL and testbench

MIX_SAR_CTRL -- requirements
Module: mix_sar_ctrl

---
 rtl/mix_sar_ctrl.sv | 145 ++++++++++++++
 tb/tb_mix_sar_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mix_sar_ctrl.sv
// -----------------------------------------------------------------------------
// mix_sar_ctrl
// Successive-approximation ADC controller. Each conversion tracks the input for
// SAMPLE_CYC cycles and then resolves one bit per cycle, MSB first. The result
// is presented on data_out together with a one-cycle valid pulse.
//
// Ports
//   oclk     : digital clock; every state change happens on its rising edge
//   rst_n    : synchronous active-low reset
//   en       : conversion enable (level); a started conversion always completes
//   cmp      : comparator decision, 1 = Vin >= DAC level (used only in CONVERT)
//   sample   : track/hold switch control, 1 = track
//   dac_code : capacitive-DAC trial code
//   busy     : high whenever the controller is not idle
//   data_out : last completed conversion result
//   valid    : one-cycle pulse on the cycle data_out has been updated
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module mix_sar_ctrl #(
    parameter int N          = 8,
    parameter int SAMPLE_CYC = 2
) (
    input  logic         oclk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         cmp,
    output logic         sample,
    output logic [N-1:0] dac_code,
    output logic         busy,
    output logic [N-1:0] data_out,
    output logic         valid
);

    localparam int KW = $clog2(N);
    localparam int CW = (SAMPLE_CYC > 1) ? $clog2(SAMPLE_CYC) : 1;
    localparam logic [KW-1:0] K_TOP    = KW'(N - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(SAMPLE_CYC - 1);
    localparam logic [N-1:0]  MSB_ONLY = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SAMPLE  = 2'd1,
        S_CONVERT = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic           sample_q, sample_d;
    logic [N-1:0]   dac_q, dac_d;
    logic           busy_q, busy_d;
    logic [N-1:0]   data_q, data_d;
    logic           valid_q, valid_d;
    logic [KW-1:0]  k_q, k_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    // State register
    always_ff @(posedge oclk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (en) state_d = S_SAMPLE;
            S_SAMPLE:  if (cnt_q == CNT_LAST) state_d = S_CONVERT;
            S_CONVERT: if (k_q == '0) state_d = S_DONE;
            S_DONE:    state_d = en ? S_SAMPLE : S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Output / datapath next values; everything holds unless changed here
    always_comb begin
        sample_d = sample_q;
        dac_d    = dac_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        k_d      = k_q;
        cnt_d    = cnt_q;
        busy_d   = (state_d != S_IDLE);
        case (state_q)
            S_IDLE, S_DONE: begin
                if (en) begin
                    sample_d = 1'b1;
                    dac_d    = '0;
                    cnt_d    = '0;
                end
            end
            S_SAMPLE: begin
                if (cnt_q == CNT_LAST) begin
                    sample_d = 1'b0;
                    dac_d    = MSB_ONLY;
                    k_d      = K_TOP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_CONVERT: begin
                // The trial bit is 1, so keeping or clearing it is just cmp.
                dac_d[k_q] = cmp;
                if (k_q != '0) begin
                    dac_d[k_q - KW'(1)] = 1'b1;
                    k_d                 = k_q - KW'(1);
                end else begin
                    data_d  = dac_d;
                    valid_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Output and datapath registers
    always_ff @(posedge oclk) begin
        if (!rst_n) begin
            sample_q <= 1'b0;
            dac_q    <= '0;
            busy_q   <= 1'b0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            k_q      <= K_TOP;
            cnt_q    <= '0;
        end else begin
            sample_q <= sample_d;
            dac_q    <= dac_d;
            busy_q   <= busy_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            k_q      <= k_d;
            cnt_q    <= cnt_d;
        end
    end

    assign sample   = sample_q;
    assign dac_code = dac_q;
    assign busy     = busy_q;
    assign data_out = data_q;
    assign valid    = valid_q;

endmodule

// File: tb/tb_mix_sar_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mix_sar_ctrl
// Scoreboard bench for mix_sar_ctrl. Stimulus pushes the expected result of
// each conversion into a queue; an independent monitor pops and compares on
// every valid pulse. The analog side is modelled as an ideal comparator on a
// held input value; outside CONVERT the comparator output is randomised.
// -----------------------------------------------------------------------------
module tb_mix_sar_ctrl;

    localparam int N  = 8;
    localparam int SC = 2;
    localparam int ALL1 = (1 << N) - 1;

    logic         oclk;
    logic         rst_n;
    logic         en;
    logic         cmp;
    logic         sample;
    logic [N-1:0] dac_code;
    logic         busy;
    logic [N-1:0] data_out;
    logic         valid;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    int vin_a  = 0;
    int cmp_mode = 0;   // 0: ideal comparator, 1: tied high, 2: tied low
    int exp_q[$];
    logic rst_smp = 1'b0;

    mix_sar_ctrl #(.N(N), .SAMPLE_CYC(SC)) dut (
        .oclk     (oclk),
        .rst_n    (rst_n),
        .en       (en),
        .cmp      (cmp),
        .sample   (sample),
        .dac_code (dac_code),
        .busy     (busy),
        .data_out (data_out),
        .valid    (valid)
    );

    initial begin
        oclk = 1'b0;
        forever #156 oclk = ~oclk;
    end

    always @(posedge oclk) begin
        cyc     <= cyc + 1;
        rst_smp <= rst_n;
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Binary-search trial code j for a converged result v: the j already
    // decided MSBs of v followed by a single 1 in the next position.
    function automatic int ref_trial(input int v, input int j);
        int keep;
        keep = ALL1 & ~((1 << (N - j)) - 1);
        return (v & keep) | (1 << (N - 1 - j));
    endfunction

    // Comparator driver, updated just after the falling edge
    initial begin
        cmp = 1'b0;
        forever begin
            @(negedge oclk);
            #1;
            if (cmp_mode == 1)                 cmp = 1'b1;
            else if (cmp_mode == 2)            cmp = 1'b0;
            else if (sample || !busy || valid) cmp = 1'($urandom_range(0, 1));
            else                               cmp = (vin_a >= int'(dac_code));
        end
    end

    // Monitor: result scoreboard, pulse width and data_out hold
    initial begin
        logic         prev_valid;
        logic [N-1:0] prev_data;
        int e;
        prev_valid = 1'b0;
        prev_data  = '0;
        forever begin
            @(negedge oclk);
            if (valid === 1'b1) begin
                chk("valid_one_cycle", int'(prev_valid), 0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("data_out", int'(data_out), e);
                end
            end else if (rst_smp === 1'b1) begin
                chk("data_out_hold", int'(data_out), int'(prev_data));
            end
            prev_valid = (valid === 1'b1);
            prev_data  = data_out;
        end
    end

    // One conversion from idle. drop_at: relative cycle at which en falls.
    // rst_at >= 0 resets the block at that relative cycle instead of finishing.
    task automatic run_conv(input int v, input int mode, input int drop_at, input int rst_at);
        int c_start;
        int rel;
        int eff;
        bit fin;
        @(negedge oclk);
        vin_a    = v;
        cmp_mode = mode;
        eff      = (mode == 1) ? ALL1 : (mode == 2) ? 0 : v;
        en       = 1'b1;
        c_start  = cyc + 1;
        if (rst_at < 0) exp_q.push_back(eff);
        fin = 0;
        for (int t = 0; t < 60 && !fin; t++) begin
            @(negedge oclk);
            rel = cyc - c_start;
            if (rel == drop_at) en = 1'b0;
            if (rel < SC) chk("sample_high", int'(sample), 1);
            if (rel >= SC && rel < SC + N) begin
                chk("trial_code", int'(dac_code), ref_trial(eff, rel - SC));
                chk("sample_low", int'(sample), 0);
                chk("busy_convert", int'(busy), 1);
            end
            if (rel == rst_at) begin
                rst_n = 1'b0;
                @(negedge oclk);
                rst_n = 1'b1;
                chk("rst_sample", int'(sample), 0);
                chk("rst_dac", int'(dac_code), 0);
                chk("rst_busy", int'(busy), 0);
                chk("rst_data", int'(data_out), 0);
                chk("rst_valid", int'(valid), 0);
                repeat (4) begin
                    @(negedge oclk);
                    chk("post_rst_idle", int'(busy), 0);
                end
                fin = 1;
            end else if (valid === 1'b1) begin
                chk("latency", rel, SC + N);
                @(negedge oclk);
                chk("done_busy_fall", int'(busy), 0);
                chk("done_dac_hold", int'(dac_code), eff);
                chk("done_sample", int'(sample), 0);
                repeat (2) begin
                    @(negedge oclk);
                    chk("idle_hold_busy", int'(busy), 0);
                    chk("idle_hold_dac", int'(dac_code), eff);
                end
                fin = 1;
            end
        end
        if (!fin) chk("conv_timeout", 0, 1);
        cmp_mode = 0;
    endtask

    // Back-to-back conversions with en held high
    task automatic run_burst();
        int vals[4];
        int prev;
        bit got;
        vals[0] = 'h5A;
        vals[1] = 'hC3;
        vals[2] = int'($urandom_range(0, ALL1));
        vals[3] = int'($urandom_range(0, ALL1));
        prev = 0;
        @(negedge oclk);
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            vin_a = vals[i];
            exp_q.push_back(vals[i]);
            got = 0;
            for (int t = 0; t < 40 && !got; t++) begin
                @(negedge oclk);
                if (valid === 1'b1) got = 1;
            end
            if (!got) chk("burst_timeout", 0, 1);
            else begin
                if (i > 0) chk("burst_period", cyc - prev, SC + N + 1);
                prev = cyc;
            end
            if (i == 3) en = 1'b0;
        end
        repeat (3) @(negedge oclk);
        chk("burst_idle", int'(busy), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b1;
        repeat (3) @(negedge oclk);
        chk("reset_sample", int'(sample), 0);
        chk("reset_dac", int'(dac_code), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_data", int'(data_out), 0);
        chk("reset_valid", int'(valid), 0);
        en = 1'b0;
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge oclk);
            chk("idle_no_start", int'(busy), 0);
        end

        run_conv(0, 1, 0, -1);                 // comparator tied high
        run_conv(0, 2, 0, -1);                 // comparator tied low
        run_conv('h5A, 0, 0, -1);              // ideal comparator, 0x5A
        run_burst();
        run_conv(int'($urandom_range(0, ALL1)), 0, SC + 3, -1);  // en drop at bit 4
        run_conv('h77, 0, 0, SC + 4);          // reset while resolving bit 3
        run_conv('h96, 0, 0, -1);
        for (int i = 0; i < 6; i++) begin
            run_conv(int'($urandom_range(0, ALL1)), 0, int'($urandom_range(0, SC + N - 1)), -1);
        end
        run_conv(ALL1, 0, 0, -1);
        run_conv(1, 0, 0, -1);

        repeat (4) @(negedge oclk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
